// File: rtl/project_4.sv
// project_4: registered 4-bit code to RGB colour decoder for a tri-colour LED.
// The switch inputs are asynchronous. Each bit goes through its own two-flop
// synchronizer. The synchronized code is decoded through a fixed colour table,
// and the result drives the LED from a register.
module project_4 (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic R,
    output logic G,
    output logic B
);

    logic [3:0] sync_1;
    logic [3:0] sync_2;
    logic [2:0] base_colour;
    logic [2:0] colour;
    logic [2:0] rgb;

    // Two-flop synchronizer, one chain per input bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 4'b0000;
            sync_2 <= 4'b0000;
        end else begin
            sync_1 <= {a, b, c, d};
            sync_2 <= sync_1;
        end
    end

    // Colour lookup. The upper eight codes are the bitwise complement of the lower eight.
    always_comb begin
        base_colour = 3'b000;
        case (sync_2[2:0])
            3'd0: base_colour = 3'b000;
            3'd1: base_colour = 3'b100;
            3'd2: base_colour = 3'b010;
            3'd3: base_colour = 3'b001;
            3'd4: base_colour = 3'b110;
            3'd5: base_colour = 3'b011;
            3'd6: base_colour = 3'b101;
            3'd7: base_colour = 3'b111;
            default: base_colour = 3'b000;
        endcase
        colour = sync_2[3] ? ~base_colour : base_colour;
    end

    // Output register. The LED only changes on a clock edge or on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= 3'b000;
        end else begin
            rgb <= colour;
        end
    end

    assign {R, G, B} = rgb;

endmodule

// File: tb/tb_project_4.sv
// Testbench for project_4. It uses a table sweep, hand-written latency, reset and
// equal-colour sequences, and random codes checked against a queue-based reference.
module tb_project_4;

    logic clk = 1'b0;
    logic rst;
    logic a, b, c, d;
    logic R, G, B;
    logic [2:0] rgb_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] idx;
        logic [2:0] rgb;
    } vec_t;

    vec_t vec [16];
    logic [2:0] observed [16];

    logic [2:0] colour_tbl [16] = '{3'b000, 3'b100, 3'b010, 3'b001,
                                    3'b110, 3'b011, 3'b101, 3'b111,
                                    3'b111, 3'b011, 3'b101, 3'b110,
                                    3'b001, 3'b100, 3'b010, 3'b000};

    // Codes seen at each rising edge since the last reset.
    logic [3:0] hist [$];

    always #5 clk = ~clk;

    assign rgb_out = {R, G, B};

    project_4 dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .R(R),
        .G(G),
        .B(B)
    );

    // Reference: the output after an edge shows the code that was sampled two edges earlier.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back({a, b, c, d});
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    function automatic logic [2:0] model_rgb();
        if (hist.size() < 3) return 3'b000;
        return colour_tbl[hist[hist.size() - 3]];
    endfunction

    task automatic set_idx(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [2:0] stale_flag(input logic [2:0] v);
        return (v == 3'b001 || v == 3'b110 || v == 3'b011) ? 3'b001 : 3'b000;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_seq [6];

        vec = '{'{4'd0, 3'b000}, '{4'd1, 3'b100}, '{4'd2, 3'b010}, '{4'd3, 3'b001},
                '{4'd4, 3'b110}, '{4'd5, 3'b011}, '{4'd6, 3'b101}, '{4'd7, 3'b111},
                '{4'd8, 3'b111}, '{4'd9, 3'b011}, '{4'd10, 3'b101}, '{4'd11, 3'b110},
                '{4'd12, 3'b001}, '{4'd13, 3'b100}, '{4'd14, 3'b010}, '{4'd15, 3'b000}};

        rst = 1'b1;
        set_idx(4'd0);
        repeat (3) after_edge();
        check("reset_state", rgb_out, 3'b000);

        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            after_edge();
            check("idle_after_reset", rgb_out, 3'b000);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        set_idx(4'd7);
        repeat (4) after_edge();
        check("white_before_reset", rgb_out, 3'b111);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset", rgb_out, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        set_idx(4'd0);
        repeat (5) begin
            after_edge();
            check("idle_after_release", rgb_out, 3'b000);
        end

        // Full table sweep
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_idx(vec[i].idx);
            repeat (10) after_edge();
            check($sformatf("sweep_idx%0d", vec[i].idx), rgb_out, vec[i].rgb);
            check($sformatf("sweep_model_idx%0d", vec[i].idx), rgb_out, model_rgb());
            observed[i] = rgb_out;
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("complement_%0d_%0d", i, i + 8), observed[i + 8], ~observed[i]);
        end

        // Latency: 0 -> 1, then 1 -> 2
        @(negedge clk);
        set_idx(4'd0);
        repeat (5) after_edge();
        @(negedge clk);
        set_idx(4'd1);
        after_edge();
        check("lat01_edge_n", rgb_out, 3'b000);
        after_edge();
        check("lat01_edge_n1", rgb_out, 3'b000);
        after_edge();
        check("lat01_edge_n2", rgb_out, 3'b100);
        @(negedge clk);
        set_idx(4'd2);
        after_edge();
        check("lat12_edge_n", rgb_out, 3'b100);
        after_edge();
        check("lat12_edge_n1", rgb_out, 3'b100);
        after_edge();
        check("lat12_edge_n2", rgb_out, 3'b010);

        // Back-to-back codes 1,2,3,4
        @(negedge clk);
        set_idx(4'd0);
        repeat (5) after_edge();
        @(negedge clk); set_idx(4'd1);
        after_edge(); check("b2b_n", rgb_out, 3'b000);
        @(negedge clk); set_idx(4'd2);
        after_edge(); check("b2b_n1", rgb_out, 3'b000);
        @(negedge clk); set_idx(4'd3);
        after_edge(); check("b2b_code1", rgb_out, 3'b100);
        @(negedge clk); set_idx(4'd4);
        after_edge(); check("b2b_code2", rgb_out, 3'b010);
        after_edge(); check("b2b_code3", rgb_out, 3'b001);
        after_edge(); check("b2b_code4", rgb_out, 3'b110);

        // Reset with codes 3,4,5 in flight
        @(negedge clk); set_idx(4'd0);
        repeat (5) after_edge();
        @(negedge clk); set_idx(4'd3);
        after_edge();
        @(negedge clk); set_idx(4'd4);
        after_edge();
        @(negedge clk); set_idx(4'd5);
        after_edge();
        @(negedge clk);
        #1 rst = 1'b1;
        set_idx(4'd6);
        #1 check("midstream_reset", rgb_out, 3'b000);
        @(negedge clk);
        #1 rst = 1'b0;
        exp_seq = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b101, 3'b101};
        for (int k = 0; k < 6; k++) begin
            after_edge();
            check($sformatf("no_stale_%0d", k), stale_flag(rgb_out), 3'b000);
            check($sformatf("after_reset_seq_%0d", k), rgb_out, exp_seq[k]);
            check($sformatf("after_reset_model_%0d", k), rgb_out, model_rgb());
        end

        // Equal-colour pairs: 0 -> 15 and 7 -> 8
        @(negedge clk); set_idx(4'd0);
        repeat (5) after_edge();
        @(negedge clk); set_idx(4'd15);
        repeat (6) begin
            after_edge();
            check("pair_0_15", rgb_out, 3'b000);
            @(negedge clk);
            check("pair_0_15_mid", rgb_out, 3'b000);
        end
        set_idx(4'd7);
        repeat (5) after_edge();
        @(negedge clk); set_idx(4'd8);
        repeat (6) begin
            after_edge();
            check("pair_7_8", rgb_out, 3'b111);
            @(negedge clk);
            check("pair_7_8_mid", rgb_out, 3'b111);
        end

        // Random codes, one per cycle
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            set_idx(4'($urandom_range(15)));
            after_edge();
            check("random", rgb_out, model_rgb());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/project_4.md
# project_4

Registered 4-bit code to RGB colour decoder. Four single-bit select inputs `a`, `b`, `c`, `d` form a code that picks one of sixteen fixed colours, driven on the `R`/`G`/`B` lines of a tri-colour indicator LED. It sits at the board-I/O edge between switch inputs and the LED driver. Inputs are treated as asynchronous, synchronised into the `clk` domain, decoded, and driven from registers.

## Interface
Parameters:
- None. The colour table is fixed.

Ports:
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high; clears all state immediately.
- `a`  input  1  code bit 3 (MSB); asynchronous to `clk`.
- `b`  input  1  code bit 2; asynchronous to `clk`.
- `c`  input  1  code bit 1; asynchronous to `clk`.
- `d`  input  1  code bit 0 (LSB); asynchronous to `clk`.
- `R`  output  1  red LED drive, active-high, registered.
- `G`  output  1  green LED drive, active-high, registered.
- `B`  output  1  blue LED drive, active-high, registered.

## Operation
- Code `idx = {a,b,c,d}`, range 0..15.
- Each input bit passes through its own two-flop synchronizer.
- The synchronized code is decoded combinationally through the colour table.
- The result is registered into `{R,G,B}`.
- Colour table, as `idx` -> `{R,G,B}`:
  - 0 -> 000 (off)
  - 1 -> 100 (red)
  - 2 -> 010 (green)
  - 3 -> 001 (blue)
  - 4 -> 110 (yellow)
  - 5 -> 011 (cyan)
  - 6 -> 101 (magenta)
  - 7 -> 111 (white)
- Codes 8..15 are the bitwise complement of code `idx-8`:
  - 8 -> 111, 9 -> 011, 10 -> 101, 11 -> 110
  - 12 -> 001, 13 -> 100, 14 -> 010, 15 -> 000
- Invariant: `{R,G,B}(idx XOR 8) == ~{R,G,B}(idx)` for every `idx`.
- Codes 0 and 15 both give off; codes 7 and 8 both give white.
- There is no state machine. The only state is the synchronizer flops and the output register.

## Timing
- Reset:
  - While `rst`=1, all synchronizer flops and the output register are 0.
  - `R`=`G`=`B`=0 immediately on `rst` rising, without waiting for a clock edge.
- After `rst` falls:
  - Outputs stay 000 until a sampled code propagates.
  - With inputs steady and `idx`=0, outputs remain 000.
- Latency: 3 rising edges.
  - A code stable before `clk` edge N is captured by sync stage 1 at N and stage 2 at N+1.
  - It appears on `{R,G,B}` after edge N+2.
  - Outputs then hold until a new code propagates.
- Throughput: one new code per cycle. Input changes on consecutive cycles appear on consecutive output cycles, in order, each 3 edges late.
- Reset mid-operation: asserting `rst` forces 000 asynchronously and discards any in-flight codes. No pre-reset code may appear after release.
- Simultaneous multi-bit input change near an edge: bits may resolve one cycle apart. At most one intermediate code's colour may show for exactly one cycle before the final colour. Codes driven synchronously and well away from edges must show no intermediate colour.
- Outputs never change except on a `clk` rising edge or `rst` assertion.

## Test plan
- Reset: drive `idx`=7, assert `rst` between edges -> `{R,G,B}`=000 immediately. Release `rst`, hold `idx`=0 -> stays 000.
- Full table sweep: apply `idx` 0..15, each held 10 cycles -> after settling, outputs match the table. Example: `idx`=5 -> 011, `idx`=13 -> 100. Check the complement invariant for all 8 pairs.
- Latency: with outputs steady at 000, change `idx` 0->1 just after edge N-1 -> `R` rises after edge N+2, not earlier. Repeat with 1->2 -> `R` falls and `G` rises on the same edge.
- Back-to-back: change `idx` every cycle in the order 1,2,3,4 -> outputs 100,010,001,110 on four consecutive cycles, starting 3 edges after the first change.
- Reset mid-stream: with codes 3,4,5 in flight, assert `rst` for one cycle -> output 000 and no 001/110/011 after release. Outputs then follow the current input with 3-edge latency.
- Equal-colour pairs: switch `idx` 0->15 and 7->8 -> no output change and no glitch.
